// File: rtl/layer_buf_ctrl.sv
// -----------------------------------------------------------------------------
// layer_buf_ctrl
//
// Fill/drain controller for one feature-map line buffer.  After a start pulse
// it accepts ROWS rows from upstream (one row of COLS bytes per handshake),
// strobing the buffer write port once per row.  It then walks the buffer in
// raster order and streams ROWS*COLS bytes to downstream through a single
// output register with valid/ready flow control.  The final byte is flagged
// with out_last.  Once it is accepted the controller parks in DONE until the
// next start.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle pulse, arms a pass from IDLE or DONE
//   row_valid  : upstream presents a complete row
//   row_ready  : controller accepts a row (FILL only)
//   wr_en      : buffer row write strobe
//   wr_row     : row index for wr_en
//   raddr      : buffer read address (combinational rdata return)
//   rdata      : buffer read data
//   out_valid  : out_data/out_last valid
//   out_data   : streamed byte
//   out_last   : marks byte ROWS*COLS-1
//   out_ready  : downstream accepts the output register
//   busy       : high in FILL or DRAIN
//   done       : high in DONE
//
// ROWS must not exceed 16 because wr_row is 4 bits wide.
// ROWS*COLS must fit in AW bits.
// -----------------------------------------------------------------------------
module layer_buf_ctrl #(
    parameter int ROWS = 14,
    parameter int COLS = 14,
    parameter int DW   = 8,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          row_valid,
    output logic          row_ready,
    output logic          wr_en,
    output logic [3:0]    wr_row,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] TOTAL    = AW'(ROWS * COLS);
    localparam logic [AW-1:0] LAST     = AW'(ROWS * COLS - 1);
    localparam logic [3:0]    ROW_LAST = 4'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_reg;
    logic [3:0]    row_cnt_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [DW-1:0] out_data_reg;
    logic          out_valid_reg;
    logic          out_last_reg;

    logic          in_fill;
    logic          in_drain;
    logic          out_take;
    logic          out_load;

    assign in_fill  = (state_reg == FILL);
    assign in_drain = (state_reg == DRAIN);

    // Downstream consumed the registered byte this cycle.
    assign out_take = out_valid_reg && out_ready;

    // The output register may be (re)loaded when it is empty or being drained
    // in the same cycle, as long as bytes remain in the buffer.  rdata is
    // combinational from raddr, so the fetch and the load happen together.
    assign out_load = (!out_valid_reg || out_ready) && (rd_ptr_reg < TOTAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            row_cnt_reg   <= 4'd0;
            rd_ptr_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= FILL;
                        row_cnt_reg <= 4'd0;
                    end
                end

                FILL: begin
                    // row_ready is constantly high here, so row_valid alone
                    // marks an accepted row.
                    if (row_valid) begin
                        row_cnt_reg <= row_cnt_reg + 4'd1;
                        if (row_cnt_reg == ROW_LAST) begin
                            state_reg  <= DRAIN;
                            rd_ptr_reg <= '0;
                        end
                    end
                end

                DRAIN: begin
                    if (out_take && out_last_reg) begin
                        // The final byte has left and no bytes remain to load.
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        state_reg     <= DONE;
                    end else if (out_load) begin
                        out_data_reg  <= rdata;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (rd_ptr_reg == LAST);
                        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                    end
                end

                DONE: begin
                    if (start) begin
                        state_reg   <= FILL;
                        row_cnt_reg <= 4'd0;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign row_ready = in_fill;
    assign wr_en     = row_valid && in_fill;
    assign wr_row    = in_fill ? row_cnt_reg : 4'd0;
    assign raddr     = in_drain ? rd_ptr_reg : '0;

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

    assign busy = in_fill || in_drain;
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_layer_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_layer_buf_ctrl
//
// Random-data bench for layer_buf_ctrl.  The bench owns the line buffer: rows
// written through wr_en/wr_row land in an array, and rdata is read back from
// it by raddr.  Each row the bench hands over is also appended, byte by byte,
// to an expected-stream queue.  A separate monitor pops that queue on every
// output handshake, so the row arrival order fixes the byte order expected
// downstream.
// -----------------------------------------------------------------------------
module tb_layer_buf_ctrl;

    localparam int ROWS  = 14;
    localparam int COLS  = 14;
    localparam int DW    = 8;
    localparam int AW    = 12;
    localparam int TOTAL = ROWS * COLS;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              row_valid;
    logic              row_ready;
    logic              wr_en;
    logic [3:0]        wr_row;
    logic [AW-1:0]     raddr;
    logic [DW-1:0]     rdata;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              done;

    logic [COLS*DW-1:0] row_data;

    layer_buf_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .row_valid(row_valid), .row_ready(row_ready),
        .wr_en(wr_en), .wr_row(wr_row),
        .raddr(raddr), .rdata(rdata),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural line buffer.
    logic [DW-1:0] buf_mem [0:TOTAL-1];

    always @(posedge clk) begin
        if (wr_en && int'(wr_row) < ROWS) begin
            for (int c = 0; c < COLS; c++)
                buf_mem[int'(wr_row) * COLS + c] <= row_data[c*DW +: DW];
        end
    end

    assign rdata = (int'(raddr) < TOTAL) ? buf_mem[int'(raddr)] : '0;

    // Scoreboard.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] pass_bytes [0:TOTAL-1];
    int            hs_cnt;
    int            checks;
    int            failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got %02h with empty queue, expected none", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("out byte %0d data=%02h last=%0b", hs_cnt, out_data, out_last);
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_last", 32'(out_last), 32'(e.last));
            end
            hs_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a pass from IDLE or DONE; the next cycle must be FILL.
    task automatic start_pass();
        hs_cnt = 0;
        exp_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("start_row_ready", 32'(row_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
    endtask

    // Supply ROWS rows with random gaps. glitch pulses start at row 5.
    task automatic fill(input bit glitch);
        for (int r = 0; r < ROWS; r++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                row_valid = 1'b0;
                #1;
                check("gap_wr_en", 32'(wr_en), 32'd0);
                check("gap_row_ready", 32'(row_ready), 32'd1);
                tick();
            end
            for (int c = 0; c < COLS; c++)
                row_data[c*DW +: DW] = DW'($urandom);
            row_valid = 1'b1;
            start = (glitch && r == 5);
            #1;
            check("fill_wr_en", 32'(wr_en), 32'd1);
            check("fill_wr_row", 32'(wr_row), 32'(r));
            $display("row %0d written", r);
            for (int c = 0; c < COLS; c++) begin
                exp_t e;
                pass_bytes[r*COLS + c] = row_data[c*DW +: DW];
                e.data = row_data[c*DW +: DW];
                e.last = (r*COLS + c == TOTAL - 1);
                exp_q.push_back(e);
            end
            tick();
            start = 1'b0;
        end
        // Now in DRAIN: extra rows must be ignored.
        row_valid = 1'b1;
        #1;
        check("post_fill_row_ready", 32'(row_ready), 32'd0);
        check("post_fill_wr_en", 32'(wr_en), 32'd0);
        check("post_fill_busy", 32'(busy), 32'd1);
        check("drain_entry_valid", 32'(out_valid), 32'd0);
        check("drain_entry_raddr", 32'(raddr), 32'd0);
    endtask

    // mode 0: out_ready held high, latency/throughput checked.
    // mode 1: random backpressure, a 3-cycle stall at byte 50, stray starts.
    // mode 2: reset asserted while byte 100 is presented.
    task automatic drain(input int mode);
        int cyc;
        int vcnt;
        int stall;
        bit aborted;
        cyc = 0;
        vcnt = 0;
        stall = 0;
        aborted = 1'b0;
        while (!done && cyc < 8 * TOTAL) begin
            if (mode == 2 && hs_cnt == 100 && out_valid) begin
                rst_n = 1'b0;
                row_valid = 1'b1;
                #1;
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_out_last", 32'(out_last), 32'd0);
                check("rst_out_data", 32'(out_data), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_raddr", 32'(raddr), 32'd0);
                check("rst_wr_en", 32'(wr_en), 32'd0);
                check("rst_wr_row", 32'(wr_row), 32'd0);
                exp_q.delete();
                tick();
                tick();
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (mode == 1 && hs_cnt == 50 && out_valid && stall < 3) begin
                out_ready = 1'b0;
                stall++;
                #1;
                check("stall_data", 32'(out_data), 32'(pass_bytes[50]));
                check("stall_raddr", 32'(raddr), 32'd51);
                check("stall_valid", 32'(out_valid), 32'd1);
            end else if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
            end else begin
                out_ready = 1'b1;
            end
            row_valid = $urandom_range(0, 1) == 1;
            #1;
            check("drain_wr_en", 32'(wr_en), 32'd0);
            if (out_valid) vcnt++;
            cyc++;
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        if (aborted) begin
            for (int i = 0; i < 4; i++) begin
                row_valid = 1'b1;
                #1;
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_wr_en", 32'(wr_en), 32'd0);
                tick();
            end
            return;
        end
        if (cyc >= 8 * TOTAL) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d cycles without done, expected done", cyc);
        end
        if (mode == 0) begin
            check("drain_cycles", 32'(cyc), 32'(TOTAL + 1));
            check("valid_cycles", 32'(vcnt), 32'(TOTAL));
        end
        check("bytes_seen", 32'(hs_cnt), 32'(TOTAL));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            row_valid = 1'b1;
            #1;
            check("done_flag", 32'(done), 32'd1);
            check("done_busy", 32'(busy), 32'd0);
            check("done_out_valid", 32'(out_valid), 32'd0);
            check("done_wr_en", 32'(wr_en), 32'd0);
            tick();
        end
        row_valid = 1'b0;
    endtask

    task automatic run_pass(input int idx, input bit glitch, input int mode);
        $display("pass %0d start mode=%0d glitch=%0b", idx, mode, glitch);
        start_pass();
        fill(glitch);
        drain(mode);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        hs_cnt    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        row_valid = 1'b1;
        out_ready = 1'b1;
        row_data  = '0;
        tick();
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_row_ready", 32'(row_ready), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_wr_row", 32'(wr_row), 32'd0);
        check("reset_raddr", 32'(raddr), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_no_start_busy", 32'(busy), 32'd0);
        check("idle_no_start_wr_en", 32'(wr_en), 32'd0);
        row_valid = 1'b0;

        run_pass(0, 1'b0, 0);
        run_pass(1, 1'b1, 1);
        run_pass(2, 1'b0, 2);
        run_pass(3, 1'b1, 1);
        run_pass(4, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/layer_buf_ctrl.md
LAYER_BUF_CTRL -- requirements
Module: layer_buf_ctrl

Interface
REQ-001 Parameter ROWS, default 14, rows per feature map.
REQ-002 Parameter COLS, default 14, bytes per row.
REQ-003 Parameter DW, default 8, data width.
REQ-004 Parameter AW, default 12, buffer read-address width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 start  in  1  single-cycle pulse; arms a fill/drain pass.
REQ-008 row_valid  in  1  upstream has one full row (COLS bytes) on its bus.
REQ-009 row_ready  out  1  controller accepts a row this cycle.
REQ-010 wr_en  out  1  buffer write strobe, one row per pulse.
REQ-011 wr_row  out  4  row index for wr_en.
REQ-012 raddr  out  AW  buffer read address.
REQ-013 rdata  in  DW  buffer read data; combinational from raddr, same cycle.
REQ-014 out_valid  out  1  out_data valid to downstream.
REQ-015 out_data  out  DW  streamed feature-map byte.
REQ-016 out_last  out  1  marks byte ROWS*COLS-1.
REQ-017 out_ready  in  1  downstream accepts out_data.
REQ-018 busy  out  1  high in FILL or DRAIN.
REQ-019 done  out  1  high in DONE.

Function
REQ-020 States IDLE, FILL, DRAIN, DONE; one-hot or binary is implementer's choice.
REQ-021 IDLE: start=1 -> FILL; row_cnt<=0.
REQ-022 FILL: row_ready=1; wr_en = row_valid & row_ready (combinational); wr_row=row_cnt.
REQ-023 FILL: on each accepted row, row_cnt increments; on acceptance with row_cnt=ROWS-1, next state DRAIN, rd_ptr<=0.
REQ-024 row_ready=0 and wr_en=0 in every state other than FILL.
REQ-025 DRAIN: raddr=rd_ptr; raddr=0 in all other states.
REQ-026 DRAIN: output register loads out_data<=rdata, out_valid<=1, out_last<=(rd_ptr==ROWS*COLS-1), and rd_ptr increments, whenever (out_valid==0 or out_ready==1) and rd_ptr<ROWS*COLS.
REQ-027 Read latency: first out_valid rises one cycle after DRAIN entry; with out_ready held high, one byte per cycle, ROWS*COLS consecutive bytes.
REQ-028 out_ready=0 with out_valid=1: out_data, out_last, out_valid and rd_ptr hold.
REQ-029 Handshake with out_last=1 accepted -> out_valid<=0, out_last<=0, next state DONE.
REQ-030 Bytes stream in raster order: address r*COLS+c, r=0..ROWS-1, c=0..COLS-1, no gaps, no repeats.
REQ-031 DONE: done=1; start=1 -> FILL with row_cnt<=0; otherwise stay.
REQ-032 start in FILL or DRAIN is ignored; no restart, no counter change.
REQ-033 row_valid outside FILL is ignored.
REQ-034 rd_ptr width AW; ROWS*COLS SHALL fit AW bits (196 < 4096).

Reset
REQ-035 rst_n=0 asynchronously forces IDLE, row_cnt=0, rd_ptr=0, out_valid=0, out_last=0, out_data=0.
REQ-036 In reset: row_ready=0, wr_en=0, wr_row=0, raddr=0, busy=0, done=0.
REQ-037 Reset asserted mid-FILL or mid-DRAIN aborts the pass; after release the block waits in IDLE for start.

Verification
REQ-038 start, row_valid held high 14 cycles -> wr_en 14 cycles, wr_row 0..13, then busy stays high, row_ready=0.
REQ-039 Fill done, out_ready=1, rdata=raddr[7:0] -> out_data 0..195 on 196 consecutive cycles, out_last only on 195, then done=1.
REQ-040 During drain, out_ready low 3 cycles at byte 50 -> out_data=50 held, raddr stays 51, stream resumes at 51 with no loss.
REQ-041 start pulsed during FILL at row 5 and during DRAIN -> no effect; row/byte counts unchanged.
REQ-042 rst_n low at byte 100 of drain -> out_valid=0, state IDLE immediately; new start restarts at wr_row 0.
REQ-043 In DONE, start -> FILL, done=0, row_ready=1 next cycle; second full pass identical to first.
